// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
//   SEG_OFF    : all segments dark (active-low pattern)
//   HEX_SEG    : hex digit to active-low {g,f,e,d,c,b,a} pattern
//   div_width  : counter width for the slot divider
//   idx_width  : counter width for the digit index (never below 1)
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int div_width(input int scan_div);
        return (scan_div > 1) ? $clog2(scan_div) : 1;
    endfunction

    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bus bundle between the CPU display register and the scan driver pins.
//   load/data/dp/blank_mask : shadowed display contents and capture strobe
//   lz_suppress             : live leading-zero suppression enable
//   seg/dp_n/an             : active-low segment, decimal point, anode drives
//   frame_start             : one-cycle pulse as digit 0's slot is presented
// master = register/CPU side, slave = scan driver.
interface seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank_mask;
    logic                  lz_suppress;
    logic [6:0]            seg;
    logic                  dp_n;
    logic [DIGITS-1:0]     an;
    logic                  frame_start;

    modport master (
        output load, data, dp, blank_mask, lz_suppress,
        input  seg, dp_n, an, frame_start
    );

    modport slave (
        input  load, data, dp, blank_mask, lz_suppress,
        output seg, dp_n, an, frame_start
    );
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-seven-segment decoder.
//   nibble : 4-bit hex value
//   seg    : active-low {g,f,e,d,c,b,a}
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex display driver for DIGITS common-anode digits.
// A load strobe captures the display word into a shadow register; the shadow
// is moved to the active register only at the end of the last digit's slot,
// so a frame is always drawn from one consistent word.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : seg_scan_driver_if slave (inputs from CPU, pin drives out)
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 2
) (
    input  logic               clk,
    input  logic               reset,
    seg_scan_driver_if.slave   bus
);

    localparam int DIV_W = div_width(SCAN_DIV);
    localparam int IDX_W = idx_width(DIGITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]      div;
    logic [IDX_W-1:0]      idx;
    logic                  div_wrap;
    logic                  commit;

    logic [4*DIGITS-1:0]   shadow_data;
    logic [DIGITS-1:0]     shadow_dp;
    logic [DIGITS-1:0]     shadow_blank;
    logic                  pending;
    logic [4*DIGITS-1:0]   active_data;
    logic [DIGITS-1:0]     active_dp;
    logic [DIGITS-1:0]     active_blank;

    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  blank_sel;
    logic                  upper_nz;
    logic                  lz_dark;
    logic                  in_guard;
    logic [DIGITS-1:0]     an_on;
    logic [6:0]            hex_seg;

    assign div_wrap = (div == DIV_LAST);
    assign commit   = div_wrap && (idx == IDX_LAST);

    // Slot divider and digit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
            idx <= '0;
        end else if (div_wrap) begin
            div <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Shadow/active double buffer. On a commit edge the active copy takes
    // the old shadow; a coincident load lands in the shadow and stays pending
    // for the following frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            pending      <= 1'b0;
            active_data  <= '0;
            active_dp    <= '0;
            active_blank <= '0;
        end else begin
            if (commit && pending) begin
                active_data  <= shadow_data;
                active_dp    <= shadow_dp;
                active_blank <= shadow_blank;
            end
            if (bus.load) begin
                shadow_data  <= bus.data;
                shadow_dp    <= bus.dp;
                shadow_blank <= bus.blank_mask;
                pending      <= 1'b1;
            end else if (commit) begin
                pending      <= 1'b0;
            end
        end
    end

    // Per-digit selection of the current slot, plus the "this digit and all
    // more significant digits are zero" test used by leading-zero suppression.
    always_comb begin
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        upper_nz  = 1'b0;
        an_on     = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_sel   = active_data[4*i +: 4];
                dp_sel    = active_dp[i];
                blank_sel = active_blank[i];
                an_on[i]  = 1'b0;
            end
            if ((IDX_W'(i) >= idx) && (active_data[4*i +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
    end

    assign lz_dark = bus.lz_suppress && (idx != '0) && !upper_nz;

    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (div < DIV_W'(GUARD));
        end
    endgenerate

    seg_hex_decode u_hex (
        .nibble (nib_sel),
        .seg    (hex_seg)
    );

    // Registered pin stage, one cycle behind idx/div.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.an          <= '1;
            bus.seg         <= SEG_OFF;
            bus.dp_n        <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= (idx == '0) && (div == '0);
            if (in_guard) begin
                bus.an   <= '1;
                bus.seg  <= SEG_OFF;
                bus.dp_n <= 1'b1;
            end else begin
                bus.an   <= an_on;
                bus.seg  <= (blank_sel || lz_dark) ? SEG_OFF : hex_seg;
                // A blanked digit hides its dp; a suppressed zero keeps it.
                bus.dp_n <= blank_sel ? 1'b1 : ~dp_sel;
            end
        end
    end

endmodule
